// File: rtl/foreign_pkg.sv
`default_nettype none
// ============================================================================
// Module  : foreign_pkg
// Purpose : Shared types and constants for the foreign (x86-64) instruction
//           record, as produced by the foreign decoder and consumed by the
//           re-encoder.
// Contents: prefix-class / escape-map enums, architectural byte constants,
//           disp/imm length encodings, decoded-instruction struct, and small
//           helpers mapping length codes to byte counts.
// Revision: 1.0 - initial release
// ============================================================================
package foreign_pkg;

  typedef enum logic [1:0] {
    PFX_NONE = 2'b00,
    PFX_66   = 2'b01,
    PFX_F2   = 2'b10,
    PFX_F3   = 2'b11
  } pfx_e;

  typedef enum logic [1:0] {
    MAP_ONE  = 2'b00,
    MAP_0F   = 2'b01,
    MAP_0F38 = 2'b10,
    MAP_0F3A = 2'b11
  } map_e;

  localparam logic [7:0] c_byte_66 = 8'h66;
  localparam logic [7:0] c_byte_f2 = 8'hF2;
  localparam logic [7:0] c_byte_f3 = 8'hF3;
  localparam logic [7:0] c_byte_0f = 8'h0F;
  localparam logic [7:0] c_byte_38 = 8'h38;
  localparam logic [7:0] c_byte_3a = 8'h3A;
  localparam logic [3:0] c_rex_base = 4'b0100;

  localparam logic [1:0] c_disp_none = 2'b00;
  localparam logic [1:0] c_disp_8    = 2'b01;
  localparam logic [1:0] c_disp_32   = 2'b10;
  localparam logic [1:0] c_disp_rsvd = 2'b11;

  localparam logic [1:0] c_imm_none = 2'b00;
  localparam logic [1:0] c_imm_8    = 2'b01;
  localparam logic [1:0] c_imm_16   = 2'b10;
  localparam logic [1:0] c_imm_32   = 2'b11;

  typedef struct packed {
    pfx_e        pfx;
    map_e        map;
    logic        rex_en;
    logic [3:0]  rex;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [1:0]  disp_len;
    logic [31:0] disp;
    logic [1:0]  imm_len;
    logic [31:0] imm;
  } insn_t;

  function automatic logic [7:0] pfx_byte(pfx_e pfx);
    case (pfx)
      PFX_66:  return c_byte_66;
      PFX_F2:  return c_byte_f2;
      PFX_F3:  return c_byte_f3;
      default: return 8'h00;
    endcase
  endfunction

  // The reserved displacement code contributes no bytes; the record is
  // flagged illegal separately.
  function automatic logic [2:0] disp_bytes(logic [1:0] len);
    case (len)
      c_disp_8:  return 3'd1;
      c_disp_32: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] imm_bytes(logic [1:0] len);
    case (len)
      c_imm_8:  return 3'd1;
      c_imm_16: return 3'd2;
      c_imm_32: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/foreign_insn_pack.sv
`default_nettype none
// ============================================================================
// Module  : foreign_insn_pack
// Purpose : Combinational assembler turning a decoded instruction record into
//           its architectural byte stream (byte 0 in bits [7:0]).
// Ports   : insn    in   decoded instruction record
//           vec     out  16-byte vector, bytes at and beyond len are zero
//           len     out  instruction length in bytes (1..15)
//           illegal out  record cannot be encoded
// Revision: 1.0 - initial release
// ============================================================================
module foreign_insn_pack
  import foreign_pkg::*;
#(
  parameter bit IS64 = 1'b1
) (
  input  insn_t        insn,
  output logic [127:0] vec,
  output logic [3:0]   len,
  output logic         illegal
);

  logic [127:0] w_vec;
  logic [3:0]   w_pos;
  logic [2:0]   w_disp_n;
  logic [2:0]   w_imm_n;

  assign w_disp_n = disp_bytes(insn.disp_len);
  assign w_imm_n  = imm_bytes(insn.imm_len);

  // Each field is appended at the running write position, so the vector is
  // built in architectural order and the final position is the length.
  always_comb begin
    w_vec = '0;
    w_pos = '0;
    if (insn.pfx != PFX_NONE) begin
      w_vec[{w_pos, 3'b000} +: 8] = pfx_byte(insn.pfx);
      w_pos = w_pos + 4'd1;
    end
    if (insn.rex_en) begin
      w_vec[{w_pos, 3'b000} +: 8] = {c_rex_base, insn.rex};
      w_pos = w_pos + 4'd1;
    end
    if (insn.map != MAP_ONE) begin
      w_vec[{w_pos, 3'b000} +: 8] = c_byte_0f;
      w_pos = w_pos + 4'd1;
    end
    if (insn.map == MAP_0F38 || insn.map == MAP_0F3A) begin
      w_vec[{w_pos, 3'b000} +: 8] = (insn.map == MAP_0F38) ? c_byte_38 : c_byte_3a;
      w_pos = w_pos + 4'd1;
    end
    w_vec[{w_pos, 3'b000} +: 8] = insn.opcode;
    w_pos = w_pos + 4'd1;
    if (insn.has_modrm) begin
      w_vec[{w_pos, 3'b000} +: 8] = insn.modrm;
      w_pos = w_pos + 4'd1;
    end
    // A sib without a modrm has nothing to qualify, so it is dropped.
    if (insn.has_modrm && insn.has_sib) begin
      w_vec[{w_pos, 3'b000} +: 8] = insn.sib;
      w_pos = w_pos + 4'd1;
    end
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_disp_n) begin
        w_vec[{w_pos, 3'b000} +: 8] = insn.disp[8*i +: 8];
        w_pos = w_pos + 4'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_imm_n) begin
        w_vec[{w_pos, 3'b000} +: 8] = insn.imm[8*i +: 8];
        w_pos = w_pos + 4'd1;
      end
    end
  end

  assign vec     = w_vec;
  assign len     = w_pos;
  assign illegal = (insn.disp_len == c_disp_rsvd) || (insn.rex_en && !IS64);

endmodule
`default_nettype wire

// File: rtl/foreign_insn_encoder.sv
`default_nettype none
// ============================================================================
// Module  : foreign_insn_encoder
// Purpose : Re-encodes a decoded foreign instruction record into its byte
//           stream and emits it in BEAT_BYTES-wide beats over valid/ready.
//           Each instruction starts on a fresh beat; illegal records produce
//           a one-cycle out_err pulse and no beats.
// Ports   : clk, rst (sync, active-low)
//           in_valid/in_ready + in_* record fields (input handshake)
//           out_valid/out_ready, out_data, out_bytes, out_last (beat stream)
//           out_err   one-cycle pulse on a rejected record
// Revision: 1.0 - initial release
// ============================================================================
module foreign_insn_encoder
  import foreign_pkg::*;
#(
  parameter bit IS64       = 1'b1,
  parameter int BEAT_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_pfx,
  input  logic [1:0]              in_map,
  input  logic                    in_rex_en,
  input  logic [3:0]              in_rex,
  input  logic [7:0]              in_opcode,
  input  logic                    in_has_modrm,
  input  logic [7:0]              in_modrm,
  input  logic                    in_has_sib,
  input  logic [7:0]              in_sib,
  input  logic [1:0]              in_disp_len,
  input  logic [31:0]             in_disp,
  input  logic [1:0]              in_imm_len,
  input  logic [31:0]             in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*BEAT_BYTES-1:0] out_data,
  output logic [3:0]              out_bytes,
  output logic                    out_last,
  output logic                    out_err
);

  localparam int         c_beat_bits = 8 * BEAT_BYTES;
  localparam logic [3:0] c_beat      = 4'(BEAT_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e       r_state, w_state_nx;
  logic [127:0] r_buf;
  logic [3:0]   r_len, r_ptr, w_ptr_nx;
  logic         w_load, w_accept, w_last;
  logic [3:0]   w_remaining;
  logic [c_beat_bits-1:0] w_shift;

  insn_t        w_insn;
  logic [127:0] w_vec;
  logic [3:0]   w_len;
  logic         w_illegal;

  assign w_insn = '{
    pfx:       pfx_e'(in_pfx),
    map:       map_e'(in_map),
    rex_en:    in_rex_en,
    rex:       in_rex,
    opcode:    in_opcode,
    has_modrm: in_has_modrm,
    modrm:     in_modrm,
    has_sib:   in_has_sib,
    sib:       in_sib,
    disp_len:  in_disp_len,
    disp:      in_disp,
    imm_len:   in_imm_len,
    imm:       in_imm
  };

  foreign_insn_pack #(.IS64(IS64)) u_pack (
    .insn    (w_insn),
    .vec     (w_vec),
    .len     (w_len),
    .illegal (w_illegal)
  );

  // Beat outputs are derived purely from registered state, so they hold
  // steady for as long as the consumer stalls.
  assign w_remaining = r_len - r_ptr;
  assign w_last      = (w_remaining <= c_beat);
  assign w_shift     = c_beat_bits'(r_buf >> {r_ptr, 3'b000});

  assign out_valid = (r_state == S_EMIT);
  assign out_data  = out_valid ? w_shift : '0;
  assign out_bytes = out_valid ? (w_last ? w_remaining : c_beat) : 4'd0;
  assign out_last  = out_valid & w_last;
  assign out_err   = (r_state == S_ERR);

  // Accepting on the final handshake lets the next instruction follow with
  // no idle cycle in between.
  assign in_ready = (r_state == S_IDLE) | (out_valid & out_ready & w_last);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx = w_illegal ? S_ERR : S_EMIT;
          w_load     = !w_illegal;
          w_ptr_nx   = 4'd0;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (!w_last) begin
            w_ptr_nx = r_ptr + c_beat;
          end else if (w_accept) begin
            w_state_nx = w_illegal ? S_ERR : S_EMIT;
            w_load     = !w_illegal;
            w_ptr_nx   = 4'd0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_ERR: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_len   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      if (w_load) begin
        r_buf <= w_vec;
        r_len <= w_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_foreign_insn_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_foreign_insn_encoder
// Purpose : Self-checking bench for foreign_insn_encoder: directed scenarios
//           with literal byte expectations plus randomized records checked
//           against a byte-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_foreign_insn_encoder;

  typedef struct {
    logic [1:0]  pfx;
    logic [1:0]  map;
    logic        rex_en;
    logic [3:0]  rex;
    logic [7:0]  opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [1:0]  disp_len;
    logic [31:0] disp;
    logic [1:0]  imm_len;
    logic [31:0] imm;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2, out_ready, out_ready2;
  logic [1:0]  in_pfx, in_map, in_disp_len, in_imm_len;
  logic        in_rex_en, in_has_modrm, in_has_sib;
  logic [3:0]  in_rex;
  logic [7:0]  in_opcode, in_modrm, in_sib;
  logic [31:0] in_disp, in_imm;
  logic        in_ready, out_valid, out_last, out_err;
  logic [63:0] out_data;
  logic [3:0]  out_bytes;
  logic        in_ready2, out_valid2, out_last2, out_err2;
  logic [63:0] out_data2;
  logic [3:0]  out_bytes2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  foreign_insn_encoder #(.IS64(1'b1), .BEAT_BYTES(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pfx(in_pfx), .in_map(in_map), .in_rex_en(in_rex_en), .in_rex(in_rex),
    .in_opcode(in_opcode), .in_has_modrm(in_has_modrm), .in_modrm(in_modrm),
    .in_has_sib(in_has_sib), .in_sib(in_sib), .in_disp_len(in_disp_len),
    .in_disp(in_disp), .in_imm_len(in_imm_len), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last), .out_err(out_err)
  );

  foreign_insn_encoder #(.IS64(1'b0), .BEAT_BYTES(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_pfx(in_pfx), .in_map(in_map), .in_rex_en(in_rex_en), .in_rex(in_rex),
    .in_opcode(in_opcode), .in_has_modrm(in_has_modrm), .in_modrm(in_modrm),
    .in_has_sib(in_has_sib), .in_sib(in_sib), .in_disp_len(in_disp_len),
    .in_disp(in_disp), .in_imm_len(in_imm_len), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_bytes(out_bytes2), .out_last(out_last2), .out_err(out_err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] pfx, input logic [1:0] map,
                              input logic rex_en, input logic [3:0] rex,
                              input logic [7:0] opc, input logic hm, input logic [7:0] modrm,
                              input logic hs, input logic [7:0] sib,
                              input logic [1:0] dl, input logic [31:0] disp,
                              input logic [1:0] il, input logic [31:0] imm);
    rec_t r;
    r.pfx = pfx; r.map = map; r.rex_en = rex_en; r.rex = rex; r.opcode = opc;
    r.has_modrm = hm; r.modrm = modrm; r.has_sib = hs; r.sib = sib;
    r.disp_len = dl; r.disp = disp; r.imm_len = il; r.imm = imm;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    in_pfx = r.pfx; in_map = r.map; in_rex_en = r.rex_en; in_rex = r.rex;
    in_opcode = r.opcode; in_has_modrm = r.has_modrm; in_modrm = r.modrm;
    in_has_sib = r.has_sib; in_sib = r.sib; in_disp_len = r.disp_len;
    in_disp = r.disp; in_imm_len = r.imm_len; in_imm = r.imm;
  endtask

  // Reference model: the architectural byte list, field by field.
  task automatic build_model(input rec_t r);
    int nd, ni;
    exp_q.delete();
    case (r.pfx)
      2'd1: exp_q.push_back(8'h66);
      2'd2: exp_q.push_back(8'hF2);
      2'd3: exp_q.push_back(8'hF3);
      default: ;
    endcase
    if (r.rex_en) exp_q.push_back({4'b0100, r.rex});
    if (r.map != 2'd0) exp_q.push_back(8'h0F);
    if (r.map == 2'd2) exp_q.push_back(8'h38);
    if (r.map == 2'd3) exp_q.push_back(8'h3A);
    exp_q.push_back(r.opcode);
    if (r.has_modrm) exp_q.push_back(r.modrm);
    if (r.has_modrm && r.has_sib) exp_q.push_back(r.sib);
    nd = (r.disp_len == 2'd1) ? 1 : (r.disp_len == 2'd2) ? 4 : 0;
    ni = (r.imm_len == 2'd1) ? 1 : (r.imm_len == 2'd2) ? 2 : (r.imm_len == 2'd3) ? 4 : 0;
    for (int i = 0; i < nd; i++) exp_q.push_back(r.disp[8*i +: 8]);
    for (int i = 0; i < ni; i++) exp_q.push_back(r.imm[8*i +: 8]);
  endtask

  task automatic set_exp(input logic [127:0] v, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  // Starts at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input rec_t r);
    int k;
    drive(r);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Checks every beat of exp_q; returns at the negedge showing the last beat.
  task automatic beats(input int stall);
    int n, nb, eb;
    logic [63:0] exp_d;
    logic [63:0] held;
    n  = exp_q.size();
    nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      exp_d = '0;
      for (int i = 0; i < 8; i++) if (8*b + i < n) exp_d[8*i +: 8] = exp_q[8*b + i];
      eb = (n - 8*b > 8) ? 8 : n - 8*b;
      chk("beat_valid", 64'(out_valid), 64'd1);
      chk("beat_data", out_data, exp_d);
      chk("beat_bytes", 64'(out_bytes), 64'(eb));
      chk("beat_last", 64'(out_last), 64'(b == nb - 1));
      if (b == 0 && stall > 0) begin
        out_ready = 1'b0;
        held = out_data;
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); @(negedge clk);
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", out_data, held);
          chk("stall_bytes", 64'(out_bytes), 64'(eb));
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
      if (b != nb - 1) begin
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  task automatic finish_idle();
    @(posedge clk); @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.pfx = 2'($urandom_range(0, 3));      r.map = 2'($urandom_range(0, 3));
    r.rex_en = 1'($urandom_range(0, 1));   r.rex = 4'($urandom);
    r.opcode = 8'($urandom);               r.has_modrm = 1'($urandom_range(0, 1));
    r.modrm = 8'($urandom);                r.has_sib = 1'($urandom_range(0, 1));
    r.sib = 8'($urandom);                  r.disp_len = 2'($urandom_range(0, 2));
    r.disp = $urandom;                     r.imm_len = 2'($urandom_range(0, 3));
    r.imm = $urandom;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r1, r2, r3, rbad;
    r1 = mk(2'd0, 2'd1, 1'b1, 4'b1000, 8'hAF, 1'b1, 8'hC1, 1'b0, 8'h00,
            2'd0, 32'h0, 2'd0, 32'h0);
    r2 = mk(2'd1, 2'd2, 1'b0, 4'h0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h24,
            2'd0, 32'h0, 2'd0, 32'h0);
    r3 = mk(2'd3, 2'd3, 1'b1, 4'hF, 8'h0F, 1'b1, 8'h84, 1'b1, 8'h88,
            2'd2, 32'h12345678, 2'd3, 32'h11223344);

    rst = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    drive(r1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_bytes", 64'(out_bytes), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;

    // Scenario 1: REX.W 0F AF /r, one beat, one cycle after accept.
    set_exp(128'hC1AF0F48, 4);
    send(r1);
    chk("s1_lo32", 64'(out_data[31:0]), 64'h00000000C1AF0F48);
    beats(0);
    finish_idle();

    // Scenario 2: 66 0F 38 00 04 24.
    set_exp(128'h240400380F66, 6);
    send(r2);
    beats(0);
    finish_idle();

    // Scenarios 3+4: 15-byte instruction, stalled beat0, back-to-back follower.
    set_exp(128'h11223344_12345678_88840F3A_0F4FF3, 15);
    send(r3);
    beats(3);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    set_exp(128'hC1AF0F48, 4);
    send(r1);
    beats(0);
    finish_idle();

    // Scenario 5: reset during beat1, with a same-cycle handshake pending.
    send(r3);
    chk("s5_beat0", 64'(out_last), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("s5_beat1", 64'(out_last), 64'd1);
    rst = 1'b0;
    drive(r2);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    chk("s5_valid", 64'(out_valid), 64'd0);
    chk("s5_in_ready", 64'(in_ready), 64'd1);
    chk("s5_bytes", 64'(out_bytes), 64'd0);
    chk("s5_last", 64'(out_last), 64'd0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("s5_quiet", 64'(out_valid), 64'd0);
    end

    // Scenario 6: reserved disp length -> single err pulse, then recover.
    rbad = r2;
    rbad.disp_len = 2'd3;
    send(rbad);
    chk("err_pulse", 64'(out_err), 64'd1);
    chk("err_no_valid", 64'(out_valid), 64'd0);
    chk("err_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("err_drop", 64'(out_err), 64'd0);
    chk("err_no_valid2", 64'(out_valid), 64'd0);
    chk("err_ready_back", 64'(in_ready), 64'd1);
    set_exp(128'h240400380F66, 6);
    send(r2);
    beats(0);
    finish_idle();

    // IS64=0 instance: REX rejected, non-REX record encodes normally.
    drive(r1);
    in_valid2 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid2 = 1'b0;
    chk("rex32_err", 64'(out_err2), 64'd1);
    chk("rex32_no_valid", 64'(out_valid2), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("rex32_err_drop", 64'(out_err2), 64'd0);
    rbad = r1;
    rbad.rex_en = 1'b0;
    drive(rbad);
    in_valid2 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid2 = 1'b0;
    chk("leg32_valid", 64'(out_valid2), 64'd1);
    chk("leg32_data", out_data2, 64'h0000000000C1AF0F);
    chk("leg32_bytes", 64'(out_bytes2), 64'd3);
    chk("leg32_last", 64'(out_last2), 64'd1);
    @(posedge clk); @(negedge clk);
    chk("leg32_idle", 64'(out_valid2), 64'd0);

    // Randomized records against the byte-list model, random stalls and
    // random back-to-back chaining.
    for (int n = 0; n < 40; n++) begin
      rec_t rr;
      rr = rand_rec();
      build_model(rr);
      send(rr);
      beats(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) finish_idle();
    end
    finish_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/foreign_insn_encoder.md
Name: foreign_insn_encoder

Overview:
Re-encodes a decoded foreign (x86-64) instruction record into its architectural byte stream. The record uses the same field layout the foreign decoder produces: prefix class, escape map, REX, opcode, modrm, sib, disp and imm. The block sits on the trace/replay and self-test path, feeding a byte-stream consumer (fetch-side loopback or debug port) in 8-byte beats. Input and output both use a valid/ready handshake.

Parameters:
IS64, 1, 64-bit mode; 0 makes any rex_en request an encoding error.
BEAT_BYTES, 8, output beat width in bytes; legal values 4 or 8.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  record valid
in_ready  out  1  record accepted when in_valid & in_ready
in_pfx  in  2  legacy prefix: 00 none, 01 66, 10 F2, 11 F3
in_map  in  2  escape map: 00 one-byte, 01 0F, 10 0F38, 11 0F3A
in_rex_en  in  1  emit REX byte
in_rex  in  4  REX W,R,X,B
in_opcode  in  8  opcode byte
in_has_modrm  in  1  emit modrm
in_modrm  in  8  modrm byte
in_has_sib  in  1  emit sib (only honoured when in_has_modrm)
in_sib  in  8  sib byte
in_disp_len  in  2  00 none, 01 disp8, 10 disp32, 11 reserved
in_disp  in  32  displacement
in_imm_len  in  2  00 none, 01 imm8, 10 imm16, 11 imm32
in_imm  in  32  immediate
out_valid  out  1  beat valid
out_ready  in  1  beat consumed when out_valid & out_ready
out_data  out  8*BEAT_BYTES  beat bytes, byte 0 in bits [7:0]
out_bytes  out  4  valid bytes in beat, 1..BEAT_BYTES, always low-aligned
out_last  out  1  final beat of the instruction
out_err  out  1  one-cycle pulse: record rejected

Behaviour:
- Byte order: prefix (66/F2/F3); REX = {4'b0100, rex}; escapes 0F / 0F 38 / 0F 3A; opcode; modrm; sib; disp little-endian; imm little-endian. The maximum length is 15 bytes.
- Length = pfx?1 + rex_en + map bytes (0/1/2/2) + 1 + has_modrm + (has_modrm&has_sib) + disp (0/1/4) + imm (0/1/2/4).
- On accept, the assembled bytes go into a 16-byte buffer along with the length. Latency is 1 cycle: out_valid rises the cycle after accept.
- FSM states:
  - IDLE: in_ready=1. Accept moves to EMIT, or to ERR if the record is illegal.
  - EMIT: presents a beat from buf[ptr]. out_bytes = min(remaining, BEAT_BYTES). out_last = (remaining <= BEAT_BYTES).
    - Handshake, not last: ptr += BEAT_BYTES.
    - Handshake on last: go to IDLE, or reload directly to EMIT if a new record is accepted the same cycle.
  - ERR: out_err=1 for one cycle, nothing emitted, then IDLE.
- in_ready = IDLE | (EMIT & out_valid & out_ready & out_last). This gives full throughput, so back-to-back instructions have no bubble.
- Illegal records: disp_len=11, or rex_en with IS64=0. has_sib without has_modrm is not illegal; sib is silently dropped.
- Each instruction starts on a fresh beat; there is no packing across instructions. Unused bytes of out_data are driven 0.
- Stall: while out_valid & ~out_ready, out_data, out_bytes and out_last are held stable.
- Reset values (rst=0 at clk edge): state IDLE, ptr 0, buffer 0, out_valid 0, out_last 0, out_bytes 0, out_err 0, in_ready 1 in the following cycle. Reset mid-instruction discards the remaining beats.
- Reset wins over any same-cycle handshake.

Decomposition:
- Package foreign_pkg holds:
  - prefix-class and map enums;
  - byte constants 8'h66, F2, F3, 0F, 38, 3A, REX base 4'b0100;
  - the decoded-instruction struct shared with the decoder;
  - disp/imm length encodings.
- Sub-module foreign_insn_pack: combinational assembler from record to 16-byte vector, 4-bit length and illegal flag. The top holds the FSM, buffer and handshake.

Test Plan:
1. rex_en=1 rex=1000, map=01, opcode AF, modrm C1 → one beat, out_data[31:0]=32'hC1AF0F48, out_bytes=4, out_last=1, arriving 1 cycle after accept.
2. pfx=01, map=10, opcode 00, modrm 04, has_sib, sib 24 → bytes 66 0F 38 00 04 24, out_bytes=6, out_last=1.
3. pfx=11, rex=F, map=11, opcode 0F, modrm 84, sib 88, disp32 12345678, imm32 11223344 → two beats:
   - beat0: F3 4F 0F 3A 0F 84 88 78, out_bytes=8, out_last=0;
   - beat1: 56 34 12 44 33 22 11, out_bytes=7, out_last=1.
4. Hold out_ready=0 for 3 cycles on beat0 of scenario 3 → beat stable, in_ready=0. Present a second record during beat1 → it is accepted on the last-beat handshake and its beat appears in the next cycle with no bubble.
5. Drive rst=0 during beat1 of scenario 3 → next cycle out_valid=0, in_ready=1, and the remaining bytes are never emitted.
6. disp_len=11 → out_err high for exactly 1 cycle, out_valid never asserted; then a legal record encodes normally. With IS64=0 and rex_en=1 → same error response.
